// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
//
// Memory-access stage of the 5-stage 32-bit RISC pipeline. It takes the
// EX/MEM bundle and performs byte/half/word loads and stores on an internal
// word-addressed data memory. It then registers the MEM/WB bundle that feeds
// write_back.
//
// Parameters
//   ADDR_WORDS        data memory depth in 32-bit words (power of two)
//
// Ports
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset of the MEM/WB register
//   stall             hold MEM/WB register, suppress store
//   flush             insert bubble into MEM/WB, suppress store (beats stall)
//   ex_valid          EX/MEM bundle valid
//   ex_alu_result     ALU result / effective byte address
//   ex_store_data     right-aligned store operand
//   ex_mem_read       load request
//   ex_mem_write      store request
//   ex_size           00 byte, 01 half, 10 word, 11 treated as word
//   ex_load_unsigned  zero-extend loads when 1, sign-extend when 0
//   ex_wb_en          instruction writes a register
//   ex_mem_to_reg     write_back selects MemoryData over alu_result
//   ex_rd             destination register
//   alu_result        registered ALU result
//   MemoryData        registered, aligned, extended load data
//   wb_en             registered register-write enable
//   mem_to_reg        registered write-back select
//   rd                registered destination register
//   misalign          registered misaligned-access flag
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int ADDR_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_size,
    input  logic        ex_load_unsigned,
    input  logic        ex_wb_en,
    input  logic        ex_mem_to_reg,
    input  logic [4:0]  ex_rd,
    output logic [31:0] alu_result,
    output logic [31:0] MemoryData,
    output logic        wb_en,
    output logic        mem_to_reg,
    output logic [4:0]  rd,
    output logic        misalign
);

    localparam int AW = $clog2(ADDR_WORDS);

    logic [31:0]   mem [ADDR_WORDS];

    logic [AW-1:0] word_idx;
    logic [1:0]    byte_off;
    logic          mem_op;
    logic          misalign_cond;
    logic          store_commit;
    logic [31:0]   read_word;
    logic [31:0]   merged_word;
    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [31:0]   load_data;
    logic          unused_addr_bits;

    // Address bits above the memory size are ignored, so accesses wrap.
    assign unused_addr_bits = ^ex_alu_result[31:AW+2];

    // Address decode and alignment check. Alignment only matters when the
    // bundle actually touches memory.
    always_comb begin
        word_idx      = ex_alu_result[AW+1:2];
        byte_off      = ex_alu_result[1:0];
        mem_op        = ex_mem_read | ex_mem_write;
        misalign_cond = 1'b0;
        case (ex_size)
            2'b00:   misalign_cond = 1'b0;
            2'b01:   misalign_cond = byte_off[0];
            default: misalign_cond = |byte_off;
        endcase
        misalign_cond = misalign_cond & mem_op;
    end

    // Combinational read of the addressed word. The read result is captured
    // at the same edge that may commit a store, so a load+store bundle sees
    // the pre-store contents.
    // The store is built as a read-modify-write of the full word, so
    // untouched byte lanes keep their old contents.
    always_comb begin
        read_word   = mem[word_idx];
        merged_word = read_word;
        case (ex_size)
            2'b00: begin
                case (byte_off)
                    2'b00:   merged_word[7:0]   = ex_store_data[7:0];
                    2'b01:   merged_word[15:8]  = ex_store_data[7:0];
                    2'b10:   merged_word[23:16] = ex_store_data[7:0];
                    default: merged_word[31:24] = ex_store_data[7:0];
                endcase
            end
            2'b01: begin
                if (byte_off[1]) begin
                    merged_word[31:16] = ex_store_data[15:0];
                end else begin
                    merged_word[15:0]  = ex_store_data[15:0];
                end
            end
            default: merged_word = ex_store_data;
        endcase
    end

    // Lane selection and sign/zero extension of load data.
    always_comb begin
        load_byte = read_word[{byte_off, 3'b000} +: 8];
        load_half = byte_off[1] ? read_word[31:16] : read_word[15:0];
        case (ex_size)
            2'b00: begin
                load_data = ex_load_unsigned ? {24'd0, load_byte}
                                             : {{24{load_byte[7]}}, load_byte};
            end
            2'b01: begin
                load_data = ex_load_unsigned ? {16'd0, load_half}
                                             : {{16{load_half[15]}}, load_half};
            end
            default: load_data = read_word;
        endcase
    end

    // A store only lands for a valid, aligned bundle that actually advances.
    // A reset held across the edge drops it.
    assign store_commit = ex_valid & ex_mem_write & ~misalign_cond
                        & ~stall & ~flush & ~reset;

    // Data memory array. It is deliberately not reset.
    always_ff @(posedge clk) begin
        if (store_commit) begin
            mem[word_idx] <= merged_word;
        end
    end

    // MEM/WB pipeline register. Flush wins over stall and produces a bubble.
    // Stall freezes everything. Invalid bundles still carry alu_result/rd
    // but never enable a write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result <= 32'd0;
            MemoryData <= 32'd0;
            wb_en      <= 1'b0;
            mem_to_reg <= 1'b0;
            rd         <= 5'd0;
            misalign   <= 1'b0;
        end else if (flush) begin
            alu_result <= ex_alu_result;
            rd         <= ex_rd;
            MemoryData <= 32'd0;
            wb_en      <= 1'b0;
            mem_to_reg <= 1'b0;
            misalign   <= 1'b0;
        end else if (!stall) begin
            alu_result <= ex_alu_result;
            rd         <= ex_rd;
            MemoryData <= (ex_valid && ex_mem_read && !misalign_cond) ? load_data : 32'd0;
            wb_en      <= ex_valid & ex_wb_en & ~misalign_cond;
            mem_to_reg <= ex_valid & ex_mem_to_reg;
            misalign   <= ex_valid & misalign_cond;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
//
// Self-checking bench for mem_access. A byte-addressed reference memory and
// a set of expected MEM/WB values are kept in the bench. Directed cases
// cover extension, misalignment, stall/flush, wrap and reset. A randomized
// phase then follows.
// ---------------------------------------------------------------------------
module tb_mem_access;

    localparam int ADDR_WORDS = 256;
    localparam int MEM_BYTES  = ADDR_WORDS * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_load_unsigned;
    logic        ex_wb_en;
    logic        ex_mem_to_reg;
    logic [4:0]  ex_rd;
    logic [31:0] alu_result;
    logic [31:0] MemoryData;
    logic        wb_en;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] exp_alu;
    logic [31:0] exp_data;
    logic        exp_wb;
    logic        exp_m2r;
    logic [4:0]  exp_rd;
    logic        exp_mis;
    logic        alu_known;
    logic        data_known;

    mem_access #(.ADDR_WORDS(ADDR_WORDS)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .ex_valid         (ex_valid),
        .ex_alu_result    (ex_alu_result),
        .ex_store_data    (ex_store_data),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_size          (ex_size),
        .ex_load_unsigned (ex_load_unsigned),
        .ex_wb_en         (ex_wb_en),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .ex_rd            (ex_rd),
        .alu_result       (alu_result),
        .MemoryData       (MemoryData),
        .wb_en            (wb_en),
        .mem_to_reg       (mem_to_reg),
        .rd               (rd),
        .misalign         (misalign)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one clock edge, computed from the current
    // bundle with byte-level memory arithmetic.
    task automatic modelStep();
        int          b;
        int          n;
        logic        mis;
        logic [31:0] v;
        logic [31:0] tmp;
        if (flush) begin
            exp_wb     = 1'b0;
            exp_m2r    = 1'b0;
            exp_mis    = 1'b0;
            exp_data   = 32'd0;
            alu_known  = 1'b0;
            data_known = 1'b1;
        end else if (!stall) begin
            b   = int'(ex_alu_result % MEM_BYTES);
            n   = (ex_size == 2'd0) ? 1 : (ex_size == 2'd1) ? 2 : 4;
            mis = (ex_mem_read || ex_mem_write) && (b % n != 0);
            exp_alu    = ex_alu_result;
            exp_rd     = ex_rd;
            alu_known  = 1'b1;
            exp_mis    = ex_valid && mis;
            exp_wb     = ex_valid && ex_wb_en && !mis;
            exp_m2r    = ex_valid && ex_mem_to_reg;
            data_known = ex_valid;
            v = 32'd0;
            if (ex_valid && ex_mem_read && !mis) begin
                for (int i = 0; i < n; i++) begin
                    v = v | (32'(ref_mem[b + i]) << (8 * i));
                end
                if (!ex_load_unsigned && n < 4 && ((v >> (8 * n - 1)) & 32'd1) == 32'd1) begin
                    v = v | (32'hFFFF_FFFF << (8 * n));
                end
            end
            exp_data = v;
            if (ex_valid && ex_mem_write && !mis) begin
                for (int i = 0; i < n; i++) begin
                    tmp = ex_store_data >> (8 * i);
                    ref_mem[b + i] = tmp[7:0];
                end
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("wb_en", {31'd0, wb_en}, {31'd0, exp_wb});
        checkOutput("mem_to_reg", {31'd0, mem_to_reg}, {31'd0, exp_m2r});
        checkOutput("misalign", {31'd0, misalign}, {31'd0, exp_mis});
        if (data_known) begin
            checkOutput("MemoryData", MemoryData, exp_data);
        end
        if (alu_known) begin
            checkOutput("alu_result", alu_result, exp_alu);
            checkOutput("rd", {27'd0, rd}, {27'd0, exp_rd});
        end
    endtask

    // Drives one bundle (called just after a falling edge), clocks it in,
    // checks the result and returns aligned to the next falling edge.
    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] sd,
                                 input logic r, input logic w, input logic [1:0] sz,
                                 input logic u, input logic we, input logic m2r,
                                 input logic [4:0] rdv, input logic st, input logic fl);
        ex_valid         = v;
        ex_alu_result    = a;
        ex_store_data    = sd;
        ex_mem_read      = r;
        ex_mem_write     = w;
        ex_size          = sz;
        ex_load_unsigned = u;
        ex_wb_en         = we;
        ex_mem_to_reg    = m2r;
        ex_rd            = rdv;
        stall            = st;
        flush            = fl;
        modelStep();
        @(posedge clk);
        #1;
        compareAll();
        @(negedge clk);
    endtask

    task automatic storeWord(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        applyStimulus(1'b1, a, d, 1'b0, 1'b1, sz, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [4:0] rdv);
        applyStimulus(1'b1, a, 32'd0, 1'b1, 1'b0, sz, u, 1'b1, 1'b1, rdv, 1'b0, 1'b0);
    endtask

    task automatic setExpZero();
        exp_alu    = 32'd0;
        exp_data   = 32'd0;
        exp_wb     = 1'b0;
        exp_m2r    = 1'b0;
        exp_rd     = 5'd0;
        exp_mis    = 1'b0;
        alu_known  = 1'b1;
        data_known = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_alu"}, alu_result, 32'd0);
        checkOutput({tag, "_data"}, MemoryData, 32'd0);
        checkOutput({tag, "_wb"}, {31'd0, wb_en}, 32'd0);
        checkOutput({tag, "_m2r"}, {31'd0, mem_to_reg}, 32'd0);
        checkOutput({tag, "_rd"}, {27'd0, rd}, 32'd0);
        checkOutput({tag, "_mis"}, {31'd0, misalign}, 32'd0);
    endtask

    initial begin
        logic [31:0] old30;
        logic [31:0] old40;
        logic [31:0] a;
        logic [1:0]  sz;

        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        ex_valid = 1'b0;
        ex_alu_result = 32'd0;
        ex_store_data = 32'd0;
        ex_mem_read = 1'b0;
        ex_mem_write = 1'b0;
        ex_size = 2'd0;
        ex_load_unsigned = 1'b0;
        ex_wb_en = 1'b0;
        ex_mem_to_reg = 1'b0;
        ex_rd = 5'd0;
        setExpZero();

        @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Give every word a known value so later loads are well defined.
        for (int w = 0; w < ADDR_WORDS; w++) begin
            storeWord(32'(w * 4), $urandom, 2'd2);
        end

        // Word store then load.
        storeWord(32'h10, 32'hDEAD_BEEF, 2'd2);
        load(32'h10, 2'd2, 1'b0, 5'd3);
        checkOutput("lw_dead", MemoryData, 32'hDEAD_BEEF);
        checkOutput("lw_dead_wb", {31'd0, wb_en}, 32'd1);
        checkOutput("lw_dead_m2r", {31'd0, mem_to_reg}, 32'd1);

        // Byte/half extension.
        storeWord(32'h20, 32'h80FF_7F01, 2'd2);
        load(32'h23, 2'd0, 1'b0, 5'd4);
        checkOutput("lb", MemoryData, 32'hFFFF_FF80);
        load(32'h23, 2'd0, 1'b1, 5'd5);
        checkOutput("lbu", MemoryData, 32'h0000_0080);
        load(32'h22, 2'd1, 1'b0, 5'd6);
        checkOutput("lh", MemoryData, 32'hFFFF_80FF);
        load(32'h20, 2'd1, 1'b1, 5'd7);
        checkOutput("lhu", MemoryData, 32'h0000_7F01);
        storeWord(32'h21, 32'h0000_00AA, 2'd0);
        load(32'h20, 2'd2, 1'b0, 5'd8);
        checkOutput("sb_lw", MemoryData, 32'h80FF_AA01);

        // Misalignment.
        load(32'h22, 2'd2, 1'b0, 5'd9);
        checkOutput("lw_mis", {31'd0, misalign}, 32'd1);
        checkOutput("lw_mis_wb", {31'd0, wb_en}, 32'd0);
        checkOutput("lw_mis_data", MemoryData, 32'd0);
        applyStimulus(1'b1, 32'h21, 32'h0000_BEEF, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("sh_mis", {31'd0, misalign}, 32'd1);
        load(32'h20, 2'd2, 1'b0, 5'd10);
        checkOutput("mis_unchanged", MemoryData, 32'h80FF_AA01);
        checkOutput("mis_one_cycle", {31'd0, misalign}, 32'd0);

        // Stall and flush.
        old30 = {ref_mem[16'h33], ref_mem[16'h32], ref_mem[16'h31], ref_mem[16'h30]};
        applyStimulus(1'b1, 32'h7, 32'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 5'd11, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h30, 32'h1234, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0);
        checkOutput("stall_hold_alu", alu_result, 32'h7);
        checkOutput("stall_hold_wb", {31'd0, wb_en}, 32'd1);
        load(32'h30, 2'd2, 1'b0, 5'd13);
        checkOutput("stall_no_write", MemoryData, old30);
        applyStimulus(1'b1, 32'h30, 32'h1234, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 5'd14, 1'b1, 1'b1);
        checkOutput("flush_wb", {31'd0, wb_en}, 32'd0);
        checkOutput("flush_data", MemoryData, 32'd0);
        load(32'h30, 2'd2, 1'b0, 5'd15);
        checkOutput("flush_no_write", MemoryData, old30);

        // Address wrap and ALU pass-through.
        storeWord(32'h400, 32'h55, 2'd2);
        load(32'h000, 2'd2, 1'b0, 5'd16);
        checkOutput("wrap", MemoryData, 32'h0000_0055);
        applyStimulus(1'b1, 32'h7, 32'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 5'd17, 1'b0, 1'b0);
        checkOutput("pass_alu", alu_result, 32'h7);
        checkOutput("pass_wb", {31'd0, wb_en}, 32'd1);
        checkOutput("pass_data", MemoryData, 32'd0);

        // Reset mid-operation with a store pending.
        old40 = {ref_mem[16'h43], ref_mem[16'h42], ref_mem[16'h41], ref_mem[16'h40]};
        load(32'h10, 2'd2, 1'b0, 5'd18);
        ex_valid      = 1'b1;
        ex_alu_result = 32'h40;
        ex_store_data = 32'h9999_9999;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b1;
        ex_size       = 2'd2;
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("rst_async");
        @(posedge clk);
        #1;
        checkAllZero("rst_held");
        @(negedge clk);
        reset = 1'b0;
        setExpZero();
        load(32'h40, 2'd2, 1'b0, 5'd19);
        checkOutput("rst_dropped", MemoryData, old40);
        load(32'h10, 2'd2, 1'b0, 5'd20);
        checkOutput("rst_persist", MemoryData, 32'hDEAD_BEEF);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            a  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) begin
                a[1:0] = 2'b00;
            end
            applyStimulus($urandom_range(0, 9) != 0, a, $urandom,
                          1'($urandom), 1'($urandom), sz, 1'($urandom),
                          1'($urandom), 1'($urandom), 5'($urandom),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
